sha256_compress_ctrl: RTL

Iterative SHA-256 compression controller. It accepts one 512-bit message block and a 256-bit chaining value over a valid/ready handshake, then runs the 64 compression rounds over multiple cycles. It generates the message schedule on the fly and returns the updated chaining value (digest) over a second valid/ready handshake. It is the area-efficient, sequenced counterpart to the fully unrolled combinational compressor, and it feeds the miner's double-hash and nonce logic.

---
 rtl/sha256_compress_ctrl_pkg.sv | 46 ++++
 rtl/sha256_compress_ctrl_round.sv | 16 +
 rtl/sha256_compress_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/sha256_compress_ctrl_pkg.sv
// sha256_compress_ctrl_pkg: SHA-256 constants, FSM state type and the sigma/choice/majority helpers
package sha256_constants;
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    typedef logic [0:7][31:0] words8_t;
    localparam logic [0:63][31:0] k_constants = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [0:255] iv = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
endpackage

package sigma_functions;
    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] upper_sigma_zero(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] upper_sigma_one(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] lower_sigma_zero(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] lower_sigma_one(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
endpackage

package bit_select_functions;
    function automatic logic [31:0] choice(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction
    function automatic logic [31:0] majority(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction
endpackage

// File: rtl/sha256_compress_ctrl_round.sv
// sha256_round: one combinational SHA-256 compression round over the a..h working words
module sha256_round
    import sha256_constants::*;
    import sigma_functions::*;
    import bit_select_functions::*;
(
    input  words8_t     s_in,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output words8_t     s_out
);
    logic [31:0] t1, t2;
    assign t1 = s_in[7] + upper_sigma_one(s_in[4]) + choice(s_in[4], s_in[5], s_in[6]) + k + w;
    assign t2 = upper_sigma_zero(s_in[0]) + majority(s_in[0], s_in[1], s_in[2]);
    assign s_out = {t1 + t2, s_in[0], s_in[1], s_in[2], s_in[3] + t1, s_in[4], s_in[5], s_in[6]};
endmodule

// File: rtl/sha256_compress_ctrl.sv
// sha256_compress_ctrl: iterative SHA-256 compressor, ROUNDS_PER_CYCLE chained rounds per clock
// with an on-the-fly 16-word message schedule window.
module sha256_compress_ctrl
    import sha256_constants::*;
    import sigma_functions::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:511] block_in,
    input  logic [0:255] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:255] digest_out,
    output logic         busy,
    output logic [5:0]   round_idx
);
    localparam int unsigned RPC = ROUNDS_PER_CYCLE;

    if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8 && RPC != 16) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_t state, state_next;
    words8_t wk, h, digest, sum;
    logic [0:15][31:0] w, w_next;
    logic accept, last;

    assign last = round_idx == 6'(64 - RPC);

    always_comb begin
        in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
        accept = in_valid && in_ready;
        state_next = accept ? ROUND : (state == ROUND && last) ? DONE : (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    assign out_valid = state == DONE;
    assign busy = state != IDLE;
    assign digest_out = digest;

    // Window extended by RPC words: entry j is W_{round_idx+j}; the tail becomes the next window.
    for (genvar j = 0; j < 16 + RPC; j++) begin : g_w
        logic [31:0] v;
        if (j < 16) begin : g_load
            assign v = w[j];
        end else begin : g_ext
            assign v = lower_sigma_one(g_w[j-2].v) + g_w[j-7].v + lower_sigma_zero(g_w[j-15].v) + g_w[j-16].v;
        end
    end

    for (genvar j = 0; j < 16; j++) begin : g_shift
        assign w_next[j] = g_w[j+RPC].v;
    end

    for (genvar r = 0; r < RPC; r++) begin : g_r
        words8_t s_in, s_out;
        if (r == 0) begin : g_first
            assign s_in = wk;
        end else begin : g_chain
            assign s_in = g_r[r-1].s_out;
        end
        sha256_round u_round (
            .s_in  (s_in),
            .k     (k_constants[round_idx + 6'(r)]),
            .w     (g_w[r].v),
            .s_out (s_out)
        );
    end

    for (genvar j = 0; j < 8; j++) begin : g_sum
        assign sum[j] = h[j] + g_r[RPC-1].s_out[j];
    end

    // round_idx wraps to 0 on the final step, so it already reads 0 in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w <= '0;
            wk <= '0;
            h <= '0;
            digest <= '0;
            round_idx <= '0;
        end else if (accept) begin
            w <= block_in;
            wk <= state_in;
            h <= state_in;
            round_idx <= '0;
        end else if (state == ROUND) begin
            w <= w_next;
            wk <= g_r[RPC-1].s_out;
            round_idx <= round_idx + 6'(RPC);
            if (last) digest <= sum;
        end
    end
endmodule
